// File: rtl/uart_pkg.sv
// uart_pkg: shared UART widths, FIFO sizing and bus register addresses
package uart_pkg;
  localparam int UART_DATA_W       = 8;
  localparam int UART_TXFIFO_DEPTH = 16;
  localparam int UART_TXFIFO_LOW   = 4;
  localparam logic [1:0] ADDR_BAUD   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_TXDATA = 2'd2;
  localparam logic [1:0] ADDR_RX     = 2'd3;
endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x DATA_W register array, sync write, async read
module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO between the TX data register and the UART transmitter
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH      = UART_TXFIFO_DEPTH,
  parameter int DATA_W     = UART_DATA_W,
  parameter int LOW_THRESH = UART_TXFIFO_LOW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       flush,
  input  logic                       clr_ovf,
  output logic                       tx_valid,
  output logic [DATA_W-1:0]          tx_data,
  input  logic                       tx_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       tx_low,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, drop;
  assign pop  = tx_valid & tx_ready;
  assign push = wr_en & (!full | pop) & !flush;
  assign drop = wr_en & full & !pop;
  assign empty    = count == '0;
  assign full     = count == CW'(DEPTH);
  assign tx_valid = !empty;
  assign tx_low   = count <= CW'(LOW_THRESH);
  uart_fifo_mem #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (tx_data)
  );
  // flush takes precedence; a dropped write outranks clr_ovf
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(push);
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + CW'(push) - CW'(pop);
      overflow <= drop ? 1'b1 : clr_ovf ? 1'b0 : overflow;
    end
endmodule
